// File: rtl/counter_updown_if.sv
// counter_updown_if: control inputs and count outputs of the up/down counter
interface counter_updown_if #(parameter int WIDTH = 4);
  logic             en_i;
  logic             dir_i;
  logic             load_i;
  logic [WIDTH-1:0] load_data_i;
  logic             clear_i;
  logic [WIDTH-1:0] data_o;
  logic             tc_o;
  logic             ovf_o;
  modport master (output en_i, dir_i, load_i, load_data_i, clear_i, input data_o, tc_o, ovf_o);
  modport slave  (input en_i, dir_i, load_i, load_data_i, clear_i, output data_o, tc_o, ovf_o);
endinterface

// File: rtl/counter_updown.sv
// counter_updown: programmable-modulus up/down counter with wrap/saturate, terminal-count pulse and sticky overflow
module counter_updown #(
  parameter int WIDTH     = 4,
  parameter int MAX_VAL   = 2**WIDTH - 1,
  parameter int RESET_VAL = 0,
  parameter bit SATURATE  = 1'b0
) (
  input logic             clock_i,
  input logic             reset_i,
  counter_updown_if.slave bus
);
  if (MAX_VAL >= 2**WIDTH || RESET_VAL > MAX_VAL || RESET_VAL < 0 || MAX_VAL < 0) begin : g_bad_params
    $error("counter_updown: need 0 <= RESET_VAL <= MAX_VAL < 2**WIDTH");
  end
  localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] L_RST = WIDTH'(RESET_VAL);
  logic [WIDTH-1:0] r_data, w_next, w_step;
  logic             r_tc, r_ovf, w_tc, w_ovf, w_at_bound;
  // next count: clear > load (clamped) > step toward dir with wrap/hold at the bound > hold
  always_comb begin
    w_at_bound = bus.dir_i ? (r_data == L_MAX) : (r_data == '0);
    w_step     = bus.dir_i ? (w_at_bound ? (SATURATE ? L_MAX : '0) : r_data + WIDTH'(1))
                           : (w_at_bound ? (SATURATE ? '0 : L_MAX) : r_data - WIDTH'(1));
    w_next     = bus.clear_i ? L_RST
               : bus.load_i  ? ((bus.load_data_i > L_MAX) ? L_MAX : bus.load_data_i)
               : bus.en_i    ? w_step : r_data;
    w_tc       = !bus.clear_i && !bus.load_i && bus.en_i && w_at_bound;
    w_ovf      = !bus.clear_i && (r_ovf || w_tc);
  end
  // registered count and flags so tc_o lines up with the post-wrap value
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_data <= L_RST;
      r_tc   <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_data <= w_next;
      r_tc   <= w_tc;
      r_ovf  <= w_ovf;
    end
  end
  assign bus.data_o = r_data;
  assign bus.tc_o   = r_tc;
  assign bus.ovf_o  = r_ovf;
endmodule

// File: tb/tb_counter_updown.sv
// tb_counter_updown: scoreboard bench for wrap (mod 10), saturate (mod 10) and default (mod 16) counters
module tb_counter_updown;
  typedef struct {int d; bit tc; bit ovf;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0, en = 1'b0, dir = 1'b0, ld = 1'b0, clr = 1'b0;
  logic [3:0] ldv = '0;
  int checks = 0, errors = 0;
  exp_t st [3];
  exp_t q0 [$], q1 [$], q2 [$];
  int maxv [3] = '{9, 9, 15};
  bit sat [3] = '{1'b0, 1'b1, 1'b0};
  always #5 clk = ~clk;
  counter_updown_if #(.WIDTH(4)) if0 ();
  counter_updown_if #(.WIDTH(4)) if1 ();
  counter_updown_if #(.WIDTH(4)) if2 ();
  assign {if0.en_i, if0.dir_i, if0.load_i, if0.clear_i, if0.load_data_i} = {en, dir, ld, clr, ldv};
  assign {if1.en_i, if1.dir_i, if1.load_i, if1.clear_i, if1.load_data_i} = {en, dir, ld, clr, ldv};
  assign {if2.en_i, if2.dir_i, if2.load_i, if2.clear_i, if2.load_data_i} = {en, dir, ld, clr, ldv};
  counter_updown #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(0), .SATURATE(1'b0)) u_wrap (.clock_i(clk), .reset_i(rst), .bus(if0));
  counter_updown #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(0), .SATURATE(1'b1)) u_sat  (.clock_i(clk), .reset_i(rst), .bus(if1));
  counter_updown #(.WIDTH(4)) u_def (.clock_i(clk), .reset_i(rst), .bus(if2));
  function automatic exp_t model(exp_t s, int mx, bit sa, bit r, bit c, bit l, int lv, bit e, bit d);
    exp_t n = s;
    n.tc = 1'b0;
    if (r || c) begin
      n.d = 0;
      n.ovf = 1'b0;
    end else if (l) n.d = (lv > mx) ? mx : lv;
    else if (e) begin
      if (d ? (s.d == mx) : (s.d == 0)) begin
        n.d = sa ? s.d : (d ? 0 : mx);
        n.tc = 1'b1;
        n.ovf = 1'b1;
      end else n.d = d ? s.d + 1 : s.d - 1;
    end
    return n;
  endfunction
  task automatic drive(bit r, bit c, bit l, int lv, bit e, bit d);
    @(negedge clk);
    rst = r; clr = c; ld = l; ldv = 4'(lv); en = e; dir = d;
    for (int k = 0; k < 3; k++) st[k] = model(st[k], maxv[k], sat[k], r, c, l, lv, e, d);
    q0.push_back(st[0]);
    q1.push_back(st[1]);
    q2.push_back(st[2]);
  endtask
  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q0.size() != 0) begin
      e = q0.pop_front();
      check("wrap.data", int'(if0.data_o), e.d);
      check("wrap.tc", int'(if0.tc_o), int'(e.tc));
      check("wrap.ovf", int'(if0.ovf_o), int'(e.ovf));
    end
    if (q1.size() != 0) begin
      e = q1.pop_front();
      check("sat.data", int'(if1.data_o), e.d);
      check("sat.tc", int'(if1.tc_o), int'(e.tc));
      check("sat.ovf", int'(if1.ovf_o), int'(e.ovf));
    end
    if (q2.size() != 0) begin
      e = q2.pop_front();
      check("def.data", int'(if2.data_o), e.d);
      check("def.tc", int'(if2.tc_o), int'(e.tc));
      check("def.ovf", int'(if2.ovf_o), int'(e.ovf));
    end
  end
  initial begin
    for (int k = 0; k < 3; k++) st[k] = '{0, 1'b0, 1'b0};
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) drive(0, 0, 0, 0, 1, 1);
    drive(0, 0, 1, 3, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 8, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 15, 1, 1);
    drive(0, 0, 1, 5, 0, 0);
    drive(0, 1, 1, 7, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    drive(1, 1, 0, 0, 1, 1);
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) drive(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 40) == 0, $urandom_range(0, 25) == 0, $urandom_range(0, 8) == 0,
            int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    @(negedge clk);
    en = 1'b0; ld = 1'b0; clr = 1'b0; rst = 1'b0;
    for (int i = 0; i < 20 && (q0.size() + q1.size() + q2.size()) != 0; i++) @(negedge clk);
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q0.size() + q1.size() + q2.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
